// File: rtl/br_predict_resolve.sv
// Branch unit: PC-indexed 2-bit saturating counter table for prediction, condition evaluation for resolve.
// Optional macro BR_STATS_EN adds br_count/miss_count resolve statistics outputs.
module br_predict_resolve #(
  parameter int         PC_W     = 16,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pred_valid,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_out_valid,
  output logic            pred_taken,
  input  logic            resolve_valid,
  input  logic [PC_W-1:0] resolve_pc,
  input  logic [2:0]      condition,
  input  logic            z,
  input  logic            ov,
  input  logic            n,
  input  logic            taken,
  output logic            miss_valid,
  output logic            miss,
  output logic            actual_taken
`ifdef BR_STATS_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int DEPTH = 2**IDX_W;

  logic [1:0]       ctr_r [DEPTH];
  logic [IDX_W-1:0] pred_idx_s;
  logic [IDX_W-1:0] res_idx_s;
  logic             act_s;
  logic             miss_s;
  logic             unused_pc_s;

  function automatic logic eval_cond(input logic [2:0] cc, input logic fz, input logic fov,
                                     input logic fn);
    logic r;
    case (cc)
      3'd0:    r = fz;
      3'd1:    r = ~(fz | fn);
      3'd2:    r = ~fn;
      3'd3:    r = fn;
      3'd4:    r = fz | fn;
      3'd5:    r = ~fz;
      3'd6:    r = fov;
      3'd7:    r = 1'b1;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
    logic [1:0] r;
    if (up) begin
      if (c == 2'b11) r = c;
      else            r = c + 2'b01;
    end else begin
      if (c == 2'b00) r = c;
      else            r = c - 2'b01;
    end
    return r;
  endfunction

  // Table indices, evaluated branch outcome and miss.
  always_comb begin
    pred_idx_s = pred_pc[IDX_W-1:0];
    res_idx_s  = resolve_pc[IDX_W-1:0];
    act_s      = eval_cond(condition, z, ov, n);
    miss_s     = act_s ^ taken;
  end

  // Upper PC bits alias onto the same entry on purpose.
  assign unused_pc_s = ^{pred_pc[PC_W-1:IDX_W], resolve_pc[PC_W-1:IDX_W]};

  // Counter table training; reads elsewhere see the pre-update value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_r[i] <= CTR_INIT;
    end else if (resolve_valid) begin
      ctr_r[res_idx_s] <= ctr_next(ctr_r[res_idx_s], act_s);
    end
  end

  // Prediction output register; direction holds while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
    end else begin
      pred_out_valid <= pred_valid;
      if (pred_valid) pred_taken <= ctr_r[pred_idx_s][1];
      else            pred_taken <= pred_taken;
    end
  end

  // Resolve output register; results clear when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_valid   <= 1'b0;
      miss         <= 1'b0;
      actual_taken <= 1'b0;
    end else begin
      miss_valid <= resolve_valid;
      if (resolve_valid) begin
        miss         <= miss_s;
        actual_taken <= act_s;
      end else begin
        miss         <= 1'b0;
        actual_taken <= 1'b0;
      end
    end
  end

`ifdef BR_STATS_EN
  // Resolve statistics, wrapping at 2**32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count   <= 32'd0;
      miss_count <= 32'd0;
    end else if (resolve_valid) begin
      br_count <= br_count + 32'd1;
      if (miss_s) miss_count <= miss_count + 32'd1;
      else        miss_count <= miss_count;
    end else begin
      br_count   <= br_count;
      miss_count <= miss_count;
    end
  end
`endif

endmodule

// File: tb/tb_br_predict_resolve.sv
// Table-driven bench for br_predict_resolve with an expected-result queue; covers BR_STATS_EN when defined.
module tb_br_predict_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_valid;
  logic [15:0] pred_pc;
  logic        pred_out_valid;
  logic        pred_taken;
  logic        resolve_valid;
  logic [15:0] resolve_pc;
  logic [2:0]  condition;
  logic        z, ov, n, taken;
  logic        miss_valid, miss, actual_taken;
`ifdef BR_STATS_EN
  logic [31:0] br_count, miss_count;
`endif

  br_predict_resolve dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .condition(condition),
    .z(z), .ov(ov), .n(n), .taken(taken),
    .miss_valid(miss_valid), .miss(miss), .actual_taken(actual_taken)
`ifdef BR_STATS_EN
    , .br_count(br_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [15:0] ppc;
    logic        rv;
    logic [15:0] rpc;
    logic [2:0]  cc;
    logic [3:0]  fl;   // {z, ov, n, taken}
    logic [4:0]  e;    // {pred_out_valid, pred_taken, miss_valid, miss, actual_taken}
  } vec_t;

  vec_t        vt[$];
  logic [4:0]  sb_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_br = 32'd0;
  logic [31:0] exp_miss = 32'd0;

  function automatic vec_t mk(input logic [1:0] pr, input logic [15:0] ppc, input logic [15:0] rpc,
                              input logic [2:0] cc, input logic [3:0] fl, input logic [4:0] e);
    vec_t v;
    v.pv = pr[1]; v.ppc = ppc; v.rv = pr[0]; v.rpc = rpc; v.cc = cc; v.fl = fl; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    pred_valid = 1'b0; pred_pc = 16'h0; resolve_valid = 1'b0; resolve_pc = 16'h0;
    condition = 3'd0; {z, ov, n, taken} = 4'b0000;
  endtask

  task automatic apply(input vec_t v, input int id);
    logic [4:0] e;
    @(negedge clk);
    pred_valid = v.pv; pred_pc = v.ppc; resolve_valid = v.rv; resolve_pc = v.rpc;
    condition = v.cc; {z, ov, n, taken} = v.fl;
    sb_q.push_back(v.e);
    if (v.rv) begin
      exp_br = exp_br + 32'd1;
      if (v.e[1]) exp_miss = exp_miss + 32'd1;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL v%0d scoreboard: got empty queue expected entry", id);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("v%0d pred_out_valid", id), {31'd0, pred_out_valid}, {31'd0, e[4]});
      chk($sformatf("v%0d pred_taken", id),     {31'd0, pred_taken},     {31'd0, e[3]});
      chk($sformatf("v%0d miss_valid", id),     {31'd0, miss_valid},     {31'd0, e[2]});
      chk($sformatf("v%0d miss", id),           {31'd0, miss},           {31'd0, e[1]});
      chk($sformatf("v%0d actual_taken", id),   {31'd0, actual_taken},   {31'd0, e[0]});
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef BR_STATS_EN
    chk({tag, " br_count"}, br_count, exp_br);
    chk({tag, " miss_count"}, miss_count, exp_miss);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Flag sets as {z, ov, n}; tt[cc][s] is the required outcome for set s.
  logic [2:0] fs [5];
  logic [4:0] tt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fs[0] = 3'b000; fs[1] = 3'b100; fs[2] = 3'b010; fs[3] = 3'b001; fs[4] = 3'b101;
    tt[0] = 5'b10010; tt[1] = 5'b00101; tt[2] = 5'b00111; tt[3] = 5'b11000;
    tt[4] = 5'b11010; tt[5] = 5'b01101; tt[6] = 5'b00100; tt[7] = 5'b11111;

    // Directed training / saturation / collision sequence at index 5.
    vt.push_back(mk(2'b10, 16'h0005, 16'h0000, 3'd0, 4'b0000, 5'b10000));
    vt.push_back(mk(2'b01, 16'h0000, 16'h0005, 3'd0, 4'b1000, 5'b00111));
    vt.push_back(mk(2'b01, 16'h0000, 16'h0005, 3'd0, 4'b1000, 5'b00111));
    vt.push_back(mk(2'b10, 16'h0005, 16'h0000, 3'd0, 4'b0000, 5'b11000));
    for (int i = 0; i < 3; i++) vt.push_back(mk(2'b01, 16'h0000, 16'h0005, 3'd7, 4'b0001, 5'b01101));
    vt.push_back(mk(2'b01, 16'h0000, 16'h0005, 3'd0, 4'b0001, 5'b01110));
    vt.push_back(mk(2'b01, 16'h0000, 16'h0005, 3'd0, 4'b0001, 5'b01110));
    vt.push_back(mk(2'b10, 16'h0005, 16'h0000, 3'd0, 4'b0000, 5'b10000));
    vt.push_back(mk(2'b01, 16'h0000, 16'h0005, 3'd0, 4'b0000, 5'b00100));
    vt.push_back(mk(2'b01, 16'h0000, 16'h0005, 3'd0, 4'b0000, 5'b00100));
    vt.push_back(mk(2'b01, 16'h0000, 16'h0005, 3'd7, 4'b0000, 5'b00111));
    vt.push_back(mk(2'b10, 16'h0005, 16'h0000, 3'd0, 4'b0000, 5'b10000));
    vt.push_back(mk(2'b11, 16'h0045, 16'h0045, 3'd7, 4'b0001, 5'b10101));
    vt.push_back(mk(2'b10, 16'h0005, 16'h0000, 3'd0, 4'b0000, 5'b11000));
    vt.push_back(mk(2'b11, 16'h0006, 16'h0005, 3'd5, 4'b1000, 5'b10100));
    vt.push_back(mk(2'b10, 16'h0005, 16'h0000, 3'd0, 4'b0000, 5'b10000));
    // Condition sweep on an otherwise unused index; pred_taken holds 0.
    for (int cc = 0; cc < 8; cc++)
      for (int s = 0; s < 5; s++)
        for (int tk = 0; tk < 2; tk++) begin
          logic a;
          logic t;
          a = tt[cc][s];
          t = (tk == 1);
          vt.push_back(mk(2'b01, 16'h0000, 16'h0014, 3'(cc), {fs[s], t}, {3'b001, a ^ t, a}));
        end

    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset pred_out_valid", {31'd0, pred_out_valid}, 32'd0);
    chk("reset pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset miss_valid", {31'd0, miss_valid}, 32'd0);
    chk("reset miss", {31'd0, miss}, 32'd0);
    chk("reset actual_taken", {31'd0, actual_taken}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_stats("reset");

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Train index 5 to strong taken, then make every output 1.
    apply(mk(2'b01, 16'h0000, 16'h0005, 3'd7, 4'b0000, 5'b00111), 1000);
    apply(mk(2'b01, 16'h0000, 16'h0005, 3'd7, 4'b0000, 5'b00111), 1001);
    apply(mk(2'b11, 16'h0005, 16'h0005, 3'd7, 4'b0000, 5'b11111), 1002);
    check_stats("pre_reset");

    // Reset between edges while a resolve is pending.
    @(negedge clk);
    resolve_valid = 1'b1; resolve_pc = 16'h0005; condition = 3'd0; {z, ov, n, taken} = 4'b0001;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst pred_out_valid", {31'd0, pred_out_valid}, 32'd0);
    chk("midrst pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("midrst miss_valid", {31'd0, miss_valid}, 32'd0);
    chk("midrst miss", {31'd0, miss}, 32'd0);
    chk("midrst actual_taken", {31'd0, actual_taken}, 32'd0);
    exp_br = 32'd0;
    exp_miss = 32'd0;
    check_stats("midrst");
    @(posedge clk);
    #1;
    chk("inrst miss_valid", {31'd0, miss_valid}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Strong-taken entry must be back at weakly not-taken.
    apply(mk(2'b10, 16'h0005, 16'h0000, 3'd0, 4'b0000, 5'b10000), 2000);
    apply(mk(2'b01, 16'h0000, 16'h0005, 3'd3, 4'b0010, 5'b00111), 2001);
    apply(mk(2'b10, 16'h0005, 16'h0000, 3'd0, 4'b0000, 5'b11000), 2002);
    check_stats("post_reset");

    @(negedge clk);
    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/br_predict_resolve.md
Name: br_predict_resolve

Overview:
- Parametrised next-generation branch unit: it predicts branches and resolves them against the flags.
- Prediction uses a PC-indexed table of 2-bit saturating counters (BHT).
- Resolution evaluates the 3-bit condition code against the z/ov/n flags, flags a misprediction, and trains the table.
- Sits between fetch (prediction port) and execute (resolve port) of the pipelined processor.

Parameters:
- PC_W, 16, width of program counter inputs.
- IDX_W, 6, table index bits; table depth = 2**IDX_W entries, index = pc[IDX_W-1:0].
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pred_valid  input  1  fetch requests a prediction this cycle.
- pred_pc  input  PC_W  PC of the branch being fetched.
- pred_out_valid  output  1  registered; prediction result valid.
- pred_taken  output  1  registered; predicted direction, equal to counter[1].
- resolve_valid  input  1  execute resolves a branch this cycle.
- resolve_pc  input  PC_W  PC of the resolving branch.
- condition  input  3  condition code.
- z  input  1  zero flag.
- ov  input  1  overflow flag.
- n  input  1  negative flag.
- taken  input  1  direction that was predicted and followed for this branch.
- miss_valid  output  1  registered; resolution result valid.
- miss  output  1  registered; actual direction differs from taken.
- actual_taken  output  1  registered; evaluated condition result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All counters are set to CTR_INIT.
  - pred_out_valid, pred_taken, miss_valid, miss and actual_taken are all 0.
- Condition codes, producing actual value a:
  - 0 Eq: a = z
  - 1 Gr: a = ~(z|n)
  - 2 GrEq: a = ~n
  - 3 Le: a = n
  - 4 LeEq: a = z|n
  - 5 NEq: a = ~z
  - 6 Ov: a = ov
  - 7 Always: a = 1 (unconditional). This is new behaviour; the previous generation forced miss = 0 here.
- Prediction path, 1-cycle latency:
  - At the edge where pred_valid=1, register pred_out_valid=1 and pred_taken=ctr[pred_pc idx][1].
  - If pred_valid=0, pred_out_valid=0 and pred_taken holds its last value.
- Resolve path, 1-cycle latency:
  - At the edge where resolve_valid=1, register miss_valid=1, actual_taken=a and miss=a^taken.
  - If resolve_valid=0, miss_valid=0; miss and actual_taken are cleared to 0.
- Counter update, on the same edge, only when resolve_valid=1:
  - a=1: counter increments, saturating at 2'b11.
  - a=0: counter decrements, saturating at 2'b00.
- Counter states:
  - 00 strong NT
  - 01 weak NT
  - 10 weak T
  - 11 strong T
- Update depends only on a, not on taken.
- Simultaneous prediction and resolve to the same index: read-before-write. The prediction reflects the pre-update counter value; the update is not bypassed.
- Simultaneous events to different indices proceed independently.
- PC bits above IDX_W are ignored, so aliasing is permitted and not detected.
- Reset asserted mid-operation: all counters and outputs return to reset values immediately; any in-flight resolve is dropped, with no update.
- Inputs while rst_n is low are ignored.

Optional Feature:
- Macro: BR_STATS_EN.
- Defined:
  - Adds outputs br_count [31:0] and miss_count [31:0], reset to 0.
  - br_count increments on each resolve_valid.
  - miss_count increments when resolve_valid and the computed miss are both 1.
  - Both counters wrap at 2**32.
- Undefined:
  - The ports and counters do not exist.
  - Functional behaviour is otherwise identical.

Test Plan:
- Reset check: release rst_n, then pred_valid=1 with pred_pc=0x0005 -> next cycle pred_out_valid=1, pred_taken=0 (counter 01).
- Training: resolve pc=0x0005, condition=0, z=1, taken=0 twice -> miss=1 both times, actual_taken=1; counter goes 01->10->11; a subsequent prediction at pc 0x0005 gives pred_taken=1.
- Saturation: from 11, resolve three times with a=1 -> counter stays 11. Then two resolves with a=0 -> 01 and pred_taken=0.
- Conditions sweep: all 8 codes with z/ov/n in {000,100,010,001,101} and taken in {0,1} -> miss equals the table above XOR taken. Code 7 gives actual_taken=1 regardless of flags.
- Collision: same-cycle pred_pc=resolve_pc=0x0045 (idx 5, aliases 0x0005) with counter 01 and a=1 -> pred_taken=0 that cycle; the next prediction reads 1.
- Async reset mid-stream: assert rst_n low between edges during resolve_valid=1 -> outputs go to 0 immediately and no counter update occurs. With BR_STATS_EN, br_count/miss_count match the counts of resolves/misses issued and are 0 after reset.
